// File: rtl/physics_scheduler.sv
// physics_scheduler: single-clock sequencer for the ball-motion datapath.
// A tick timer raises a pending request every TICK_DIV cycles; each request
// runs the sin -> acc -> vel -> pos stages in order. Each stage gets a
// one-cycle start strobe and is then given STAGE_TIMEOUT cycles to report
// done. The collision vector is snapshotted once per tick so that later
// stages all see the same value.
module physics_scheduler #(
  parameter int TICK_DIV      = 262144,
  parameter int STAGE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        flush,
  input  logic [3:0]  collision,
  input  logic [3:0]  done,
  output logic [3:0]  start,
  output logic [3:0]  col_snap,
  output logic        tick_done,
  output logic        busy,
  output logic [15:0] tick_count,
  output logic [7:0]  overrun_cnt,
  output logic [3:0]  err
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int TO_W  = $clog2(STAGE_TIMEOUT) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(STAGE_TIMEOUT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] S_SIN  = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_VEL  = 3'd4;
  localparam logic [2:0] S_POS  = 3'd5;
  localparam logic [2:0] COMMIT = 3'd6;

  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic             pending;
  logic [TO_W-1:0]  wait_cnt;

  logic       wrap;
  logic       launch;
  logic       in_stage;
  logic       stage_wait;
  logic [1:0] stage_idx;
  logic       stage_done;
  logic       stage_expired;

  // Decode timer wrap, the active stage and whether it should advance now.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    stage_idx = 2'd0;
    in_stage  = 1'b0;
    case (state)
      S_SIN: begin stage_idx = 2'd0; in_stage = 1'b1; end
      S_ACC: begin stage_idx = 2'd1; in_stage = 1'b1; end
      S_VEL: begin stage_idx = 2'd2; in_stage = 1'b1; end
      S_POS: begin stage_idx = 2'd3; in_stage = 1'b1; end
      default: ;
    endcase
    wrap          = run && (div_cnt == DIV_LAST);
    launch        = (state == WAIT) && pending;
    // The strobe cycle is the only stage cycle with a start bit high.
    stage_wait    = in_stage && (start == 4'b0000);
    stage_done    = stage_wait && done[stage_idx];
    stage_expired = stage_wait && !done[stage_idx] && (wait_cnt == TO_LAST);
  end

  // Tick timer, pending request and overrun accounting.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      div_cnt     <= '0;
      pending     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (flush) begin
      div_cnt <= '0;
      pending <= 1'b0;
    end else begin
      if (!run)
        div_cnt <= '0;
      else if (wrap)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DIV_W'(1);

      if (launch) begin
        // A wrap on the launch edge becomes the next request, not an overrun.
        pending <= wrap;
      end else if (wrap) begin
        if (pending && (overrun_cnt != 8'hFF))
          overrun_cnt <= overrun_cnt + 8'd1;
        pending <= 1'b1;
      end
    end
  end

  // Sequencer state, stage strobes, snapshot, commit and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start      <= 4'b0000;
      col_snap   <= 4'b0000;
      tick_done  <= 1'b0;
      busy       <= 1'b0;
      tick_count <= 16'd0;
      err        <= 4'b0000;
      wait_cnt   <= '0;
    end else if (flush) begin
      // Abort without committing; snapshot, counters and errors are kept.
      state     <= IDLE;
      start     <= 4'b0000;
      tick_done <= 1'b0;
      busy      <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      start     <= 4'b0000;
      tick_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run)
            state <= WAIT;
        end
        WAIT: begin
          if (pending) begin
            state    <= S_SIN;
            start    <= 4'b0001;
            col_snap <= collision;
            busy     <= 1'b1;
            wait_cnt <= '0;
          end else if (!run) begin
            state <= IDLE;
          end
        end
        S_SIN, S_ACC, S_VEL, S_POS: begin
          if (stage_done || stage_expired) begin
            if (stage_expired)
              err[stage_idx] <= 1'b1;
            wait_cnt <= '0;
            if (state == S_POS) begin
              state     <= COMMIT;
              tick_done <= 1'b1;
            end else begin
              state <= state + 3'd1;
              start <= 4'b0001 << (stage_idx + 2'd1);
            end
          end else if (stage_wait) begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        COMMIT: begin
          tick_count <= tick_count + 16'd1;
          busy       <= 1'b0;
          state      <= run ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_physics_scheduler.sv
// Directed bench for physics_scheduler with TICK_DIV=16, STAGE_TIMEOUT=4.
module tb_physics_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        flush;
  logic [3:0]  collision;
  logic [3:0]  done;
  logic [3:0]  start;
  logic [3:0]  col_snap;
  logic        tick_done;
  logic        busy;
  logic [15:0] tick_count;
  logic [7:0]  overrun_cnt;
  logic [3:0]  err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  physics_scheduler #(.TICK_DIV(16), .STAGE_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .flush      (flush),
    .collision  (collision),
    .done       (done),
    .start      (start),
    .col_snap   (col_snap),
    .tick_done  (tick_done),
    .busy       (busy),
    .tick_count (tick_count),
    .overrun_cnt(overrun_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  done;
    logic [3:0]  col;
    logic [3:0]  exp_start;
    logic        exp_td;
    logic        exp_busy;
    logic [15:0] exp_tc;
    logic [3:0]  exp_snap;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // Advance one clock; outputs are then stable and inputs may be changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until start[0] rises; n is the step count, -1 if the budget ran out.
  task automatic wait_start0(input int budget, output int n, output logic td_seen);
    int k;
    k = 0;
    td_seen = 1'b0;
    n = -1;
    while (k < budget) begin
      step();
      k++;
      if (tick_done) td_seen = 1'b1;
      if (start[0]) begin
        n = k;
        break;
      end
    end
  endtask

  // From the strobe cycle of stage idx, pulse done on its first wait cycle.
  task automatic advance_stage(input int idx);
    done = 4'b0000;
    step();
    done = 4'b0001 << idx;
    step();
    done = 4'b0000;
  endtask

  initial begin
    int   n;
    logic td_seen;
    logic flag;

    //              done     col      start    td    busy  tc      snap
    tbl[0] = '{4'b0000, 4'b0011, 4'b0001, 1'b0, 1'b1, 16'd0, 4'b0011};
    tbl[1] = '{4'b1111, 4'b0011, 4'b0000, 1'b0, 1'b1, 16'd0, 4'b0011};
    tbl[2] = '{4'b0001, 4'b0011, 4'b0010, 1'b0, 1'b1, 16'd0, 4'b0011};
    tbl[3] = '{4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b1, 16'd0, 4'b0011};
    tbl[4] = '{4'b0010, 4'b1100, 4'b0100, 1'b0, 1'b1, 16'd0, 4'b0011};
    tbl[5] = '{4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b1, 16'd0, 4'b0011};
    tbl[6] = '{4'b0100, 4'b1100, 4'b1000, 1'b0, 1'b1, 16'd0, 4'b0011};
    tbl[7] = '{4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b1, 16'd0, 4'b0011};
    tbl[8] = '{4'b1000, 4'b1100, 4'b0000, 1'b1, 1'b1, 16'd0, 4'b0011};
    tbl[9] = '{4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0, 16'd1, 4'b0011};

    rst = 1'b1; run = 1'b0; flush = 1'b0; collision = 4'b0000; done = 4'b0000;
    repeat (3) step();
    check("rst start",    32'(start),       32'h0);
    check("rst col_snap", 32'(col_snap),    32'h0);
    check("rst tick_done",32'(tick_done),   32'h0);
    check("rst busy",     32'(busy),        32'h0);
    check("rst tick_cnt", 32'(tick_count),  32'h0);
    check("rst overrun",  32'(overrun_cnt), 32'h0);
    check("rst err",      32'(err),         32'h0);

    // Nominal: first pending appears 16 edges after release.
    rst = 1'b0; run = 1'b1; collision = 4'b0011;
    flag = 1'b0;
    repeat (16) begin
      step();
      if (start != 4'b0000 || busy) flag = 1'b1;
    end
    check("no early start", 32'(flag), 32'h0);

    for (int i = 0; i < 10; i++) begin
      done      = tbl[i].done;
      collision = tbl[i].col;
      step();
      check($sformatf("nom[%0d] start", i),    32'(start),      32'(tbl[i].exp_start));
      check($sformatf("nom[%0d] tick_done", i),32'(tick_done),  32'(tbl[i].exp_td));
      check($sformatf("nom[%0d] busy", i),     32'(busy),       32'(tbl[i].exp_busy));
      check($sformatf("nom[%0d] tick_cnt", i), 32'(tick_count), 32'(tbl[i].exp_tc));
      check($sformatf("nom[%0d] col_snap", i), 32'(col_snap),   32'(tbl[i].exp_snap));
    end
    done = 4'b0000;
    check("nom err", 32'(err), 32'h0);

    // Timeout in S_VEL; wrong-stage done bits are asserted and must be ignored.
    wait_start0(40, n, td_seen);
    check("to start gap", 32'(n), 32'd7);
    check("to col_snap",  32'(col_snap), 32'h3 << 2);
    advance_stage(0);
    check("to start acc", 32'(start), 32'b0010);
    advance_stage(1);
    check("to start vel", 32'(start), 32'b0100);
    done = 4'b1011;
    flag = 1'b0;
    repeat (4) begin
      step();
      if (start != 4'b0000) flag = 1'b1;
    end
    check("to vel held", 32'(flag), 32'h0);
    step();
    done = 4'b0000;
    check("to start pos", 32'(start), 32'b1000);
    check("to err",       32'(err),   32'b0100);
    advance_stage(3);
    check("to tick_done", 32'(tick_done),  32'h1);
    check("to tc before", 32'(tick_count), 32'd1);
    step();
    check("to tc after",  32'(tick_count), 32'd2);
    check("to busy off",  32'(busy),       32'h0);

    // run dropped during S_SIN: sequence completes, then IDLE.
    wait_start0(40, n, td_seen);
    check("drop start gap", 32'(n), 32'd4);
    run = 1'b0;
    advance_stage(0);
    advance_stage(1);
    advance_stage(2);
    advance_stage(3);
    check("drop tick_done", 32'(tick_done), 32'h1);
    step();
    check("drop tick_cnt", 32'(tick_count), 32'd3);
    check("drop busy",     32'(busy),       32'h0);
    flag = 1'b0;
    repeat (40) begin
      step();
      if (start != 4'b0000 || busy) flag = 1'b1;
    end
    check("drop stays idle", 32'(flag), 32'h0);

    // Flush in S_ACC.
    run = 1'b1; collision = 4'b0110;
    wait_start0(40, n, td_seen);
    check("fl start gap", 32'(n), 32'd17);
    advance_stage(0);
    check("fl in acc", 32'(start), 32'b0010);
    collision = 4'b1001;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl start",     32'(start),      32'h0);
    check("fl busy",      32'(busy),       32'h0);
    check("fl tick_done", 32'(tick_done),  32'h0);
    check("fl tick_cnt",  32'(tick_count), 32'd3);
    check("fl err held",  32'(err),        32'b0100);
    check("fl snap held", 32'(col_snap),   32'b0110);
    wait_start0(40, n, td_seen);
    check("fl restart gap", 32'(n),       32'd17);
    check("fl no commit",   32'(td_seen), 32'h0);
    check("fl new snap",    32'(col_snap),32'b1001);

    // Reset asserted in S_POS clears everything.
    advance_stage(0);
    advance_stage(1);
    advance_stage(2);
    check("rp in pos", 32'(start), 32'b1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rp start",     32'(start),       32'h0);
    check("rp col_snap",  32'(col_snap),    32'h0);
    check("rp tick_done", 32'(tick_done),   32'h0);
    check("rp busy",      32'(busy),        32'h0);
    check("rp tick_cnt",  32'(tick_count),  32'h0);
    check("rp overrun",   32'(overrun_cnt), 32'h0);
    check("rp err",       32'(err),         32'h0);

    // Overrun: done withheld so every sequence takes 21 cycles.
    done = 4'b0000;
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (overrun_cnt != 8'd0) begin
        n = k;
        break;
      end
    end
    check("ov first edge", 32'(n),           32'd80);
    check("ov first cnt",  32'(overrun_cnt), 32'd1);
    check("ov tick_cnt",   32'(tick_count),  32'd2);
    check("ov err",        32'(err),         32'b1111);
    repeat (24000) step();
    check("ov saturate",   32'(overrun_cnt), 32'd255);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
